// File: rtl/mailbox_pkg.sv
// Shared constants and state types for the BAR1 host<->core mailbox.
package mailbox_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] TOHOST_ADDR_DEF   = 32'h0008_C120;
  localparam logic [31:0] FROMHOST_ADDR_DEF = 32'h0008_C128;
  localparam logic [31:0] STATUS_ADDR_DEF   = 32'h0008_C130;
  localparam int          CNT_W_DEF         = 16;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/bar1_tohost_mailbox_vdip_sync2.sv
// Two-flop synchroniser with async active-low reset; output is 0 until the input has been high for two edges.
module vdip_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q, ff2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/bar1_tohost_mailbox.sv
// AXI4-Lite BAR1 responder holding the TOHOST/FROMHOST mailbox, STATUS counters and core reset release.
//
//   state  | meaning
//   W_IDLE | collecting AW and W beats independently; commit once both are held
//   W_RESP | bvalid asserted, waiting for bready
//   R_IDLE | arready asserted, waiting for an AR handshake
//   R_DATA | rvalid asserted with captured rdata/rresp, waiting for rready
module bar1_tohost_mailbox
  import mailbox_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR   = TOHOST_ADDR_DEF,
  parameter logic [31:0] FROMHOST_ADDR = FROMHOST_ADDR_DEF,
  parameter logic [31:0] STATUS_ADDR   = STATUS_ADDR_DEF,
  parameter int          CNT_W         = CNT_W_DEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [15:0] sh_cl_vdip,
  output logic        core_rst_n,
  input  logic        core_tohost_we,
  input  logic [31:0] core_tohost_wd,
  output logic [31:0] tohost_q,
  output logic [31:0] fromhost_q
);

  wr_state_e        wr_state_q, wr_state_d;
  rd_state_e        rd_state_q, rd_state_d;
  logic             en_q;
  logic             aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:2]      awaddr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic [1:0]       bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      tohost_d, fromhost_d;
  logic [CNT_W-1:0] core_cnt_q, core_cnt_d, coll_cnt_q, coll_cnt_d;
  logic             commit, hit_to, hit_from, hit_status;
  logic [31:0]      rd_word, status_w;
  logic             unused_ok;

  // Ready outputs stay low until the first edge after reset is released.
  assign awready = en_q && (wr_state_q == W_IDLE) && !aw_held_q;
  assign wready  = en_q && (wr_state_q == W_IDLE) && !w_held_q;
  assign bvalid  = (wr_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = en_q && (rd_state_q == R_IDLE);
  assign rvalid  = (rd_state_q == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign status_w   = {coll_cnt_q, core_cnt_q};
  assign commit     = (wr_state_q == W_IDLE) && aw_held_q && w_held_q;
  assign hit_to     = ({awaddr_q, 2'b00} == TOHOST_ADDR);
  assign hit_from   = ({awaddr_q, 2'b00} == FROMHOST_ADDR);
  assign hit_status = ({awaddr_q, 2'b00} == STATUS_ADDR);
  assign rd_word    = {araddr[31:2], 2'b00};
  assign unused_ok  = ^{awaddr[1:0], araddr[1:0], sh_cl_vdip[15:1]};

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (awvalid && awready) aw_held_d = 1'b1;
        if (wvalid && wready)   w_held_d  = 1'b1;
        if (commit) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bresp_d    = (hit_to || hit_from || hit_status) ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: if (bready) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Core write beats a simultaneous host TOHOST commit; STATUS write clears both counters.
  always_comb begin
    tohost_d   = tohost_q;
    fromhost_d = fromhost_q;
    core_cnt_d = core_cnt_q;
    coll_cnt_d = coll_cnt_q;
    if (core_tohost_we)
      tohost_d = core_tohost_wd;
    else if (commit && hit_to)
      tohost_d = merge_bytes(tohost_q, wdata_q, wstrb_q);
    if (commit && hit_from)
      fromhost_d = merge_bytes(fromhost_q, wdata_q, wstrb_q);
    if (commit && hit_status) begin
      core_cnt_d = '0;
      coll_cnt_d = '0;
    end else begin
      if (core_tohost_we && (core_cnt_q != '1))
        core_cnt_d = core_cnt_q + CNT_W'(1);
      if (core_tohost_we && commit && hit_to && (coll_cnt_q != '1))
        coll_cnt_d = coll_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          rd_state_d = R_DATA;
          rresp_d    = RESP_OKAY;
          if (rd_word == TOHOST_ADDR)        rdata_d = tohost_q;
          else if (rd_word == FROMHOST_ADDR) rdata_d = fromhost_q;
          else if (rd_word == STATUS_ADDR)   rdata_d = status_w;
          else begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end
        end
      end
      R_DATA: if (rready) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      en_q       <= 1'b0;
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      tohost_q   <= '0;
      fromhost_q <= '0;
      core_cnt_q <= '0;
      coll_cnt_q <= '0;
    end else begin
      en_q       <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      if (awvalid && awready) awaddr_q <= awaddr[31:2];
      if (wvalid && wready) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      tohost_q   <= tohost_d;
      fromhost_q <= fromhost_d;
      core_cnt_q <= core_cnt_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  vdip_sync2 u_vdip_sync2 (
    .clk_i   (clk_main_a0),
    .rst_n_i (rst_main_n),
    .d_i     (sh_cl_vdip[0]),
    .q_o     (core_rst_n)
  );

endmodule
